// File: rtl/single_bus_datapath_if.sv
// Signal bundle between the ControlUnit (master) and the single-bus datapath (slave).
//
// Strobe semantics: there is no valid/ready handshake. Every strobe is a
// level that the datapath samples on each rising clock edge. End=1 marks the
// controller as idle: the datapath ignores all in/out strobes and only the
// side-load port (LoadEn/LoadSel/LoadData) acts. End=0 means every asserted
// strobe takes effect at that edge, with no back-pressure from the datapath.
interface single_bus_datapath_if #(
  parameter int WIDTH = 8
);

  // Register load / bus-drive strobes
  logic             R1in;
  logic             R1out;
  logic             R2in;
  logic             R2out;

  // ALU operation select and operand A source
  logic             Add;
  logic             Sub;
  logic             Mul;
  logic             Div;
  logic             SelectY;

  // Y / Z strobes
  logic             Yin;
  logic             Zin;
  logic             Zout;

  // Controller idle indication and side-load port
  logic             End;
  logic             LoadEn;
  logic             LoadSel;
  logic [WIDTH-1:0] LoadData;

  // Datapath observation outputs
  logic [WIDTH-1:0] Bus;
  logic [WIDTH-1:0] R1Value;
  logic [WIDTH-1:0] R2Value;
  logic [WIDTH-1:0] ZValue;
  logic             Carry;
  logic             ZeroFlag;
  logic             DivByZero;
  logic             BusConflict;

  // Controller side: drives strobes, observes datapath state
  modport master (
    output R1in, R1out, R2in, R2out,
    output Add, Sub, Mul, Div, SelectY,
    output Yin, Zin, Zout,
    output End, LoadEn, LoadSel, LoadData,
    input  Bus, R1Value, R2Value, ZValue,
    input  Carry, ZeroFlag, DivByZero, BusConflict
  );

  // Datapath side: consumes strobes, reports state
  modport slave (
    input  R1in, R1out, R2in, R2out,
    input  Add, Sub, Mul, Div, SelectY,
    input  Yin, Zin, Zout,
    input  End, LoadEn, LoadSel, LoadData,
    output Bus, R1Value, R2Value, ZValue,
    output Carry, ZeroFlag, DivByZero, BusConflict
  );

endinterface

// File: rtl/single_bus_datapath.sv
// Single-bus datapath: R1, R2, Y and Z share one bus driven by at most one of
// R1/R2/Z. The ALU takes A from Y (or the constant 1) and B from the bus, and
// its result plus flags are captured into Z. While the controller is idle
// (End=1) a side-load port initialises R1/R2.
module single_bus_datapath #(
  parameter int WIDTH = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  single_bus_datapath_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  // Architectural state
  logic [WIDTH-1:0] r1_q, r1_d;
  logic [WIDTH-1:0] r2_q, r2_d;
  logic [WIDTH-1:0] y_q,  y_d;
  logic [WIDTH-1:0] z_q,  z_d;
  logic             carry_q,    carry_d;
  logic             zero_q,     zero_d;
  logic             dbz_q,      dbz_d;
  logic             conflict_q, conflict_d;

  // Bus arbitration
  logic             active;
  logic             drv_r1;
  logic             drv_r2;
  logic             drv_z;
  logic [1:0]       drv_count;
  logic             conflict_now;
  logic [WIDTH-1:0] bus_val;

  // ALU
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [WIDTH:0]     sum_w;
  logic [2*WIDTH-1:0] prod_w;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_carry;
  logic               alu_zero;
  logic               alu_dbz;

  // Bus driver selection; out-strobes only count while the controller runs
  always_comb begin
    active       = ~bus.End;
    drv_r1       = active & bus.R1out;
    drv_r2       = active & bus.R2out;
    drv_z        = active & bus.Zout;
    drv_count    = {1'b0, drv_r1} + {1'b0, drv_r2} + {1'b0, drv_z};
    conflict_now = (drv_count > 2'd1);
    bus_val      = '0;
    if (drv_count == 2'd1) begin
      if (drv_r1) begin
        bus_val = r1_q;
      end else if (drv_r2) begin
        bus_val = r2_q;
      end else begin
        bus_val = z_q;
      end
    end
  end

  // ALU: fixed priority Add > Sub > Mul > Div, pass-through of B otherwise
  always_comb begin
    alu_a      = bus.SelectY ? y_q : ONE;
    alu_b      = bus_val;
    sum_w      = {1'b0, alu_a} + {1'b0, alu_b};
    prod_w     = {{WIDTH{1'b0}}, alu_a} * {{WIDTH{1'b0}}, alu_b};
    alu_result = alu_b;
    alu_carry  = 1'b0;
    alu_dbz    = 1'b0;
    if (bus.Add) begin
      alu_result = sum_w[WIDTH-1:0];
      alu_carry  = sum_w[WIDTH];
    end else if (bus.Sub) begin
      alu_result = alu_a - alu_b;
      alu_carry  = (alu_a < alu_b);
    end else if (bus.Mul) begin
      alu_result = prod_w[WIDTH-1:0];
      alu_carry  = |prod_w[2*WIDTH-1:WIDTH];
    end else if (bus.Div) begin
      if (alu_b == '0) begin
        alu_result = ALL_ONES;
        alu_dbz    = 1'b1;
      end else begin
        alu_result = alu_a / alu_b;
      end
    end
    alu_zero = (alu_result == '0);
  end

  // Next-state: side-load while idle, strobe-driven transfers while running
  always_comb begin
    r1_d       = r1_q;
    r2_d       = r2_q;
    y_d        = y_q;
    z_d        = z_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    dbz_d      = dbz_q;
    conflict_d = conflict_q;
    if (bus.End) begin
      if (bus.LoadEn) begin
        if (bus.LoadSel) begin
          r2_d = bus.LoadData;
        end else begin
          r1_d = bus.LoadData;
        end
      end
    end else begin
      // All in-strobes see the same bus value, so a register driving the
      // bus and loading in the same cycle simply reloads its old contents.
      if (bus.R1in) begin
        r1_d = bus_val;
      end
      if (bus.R2in) begin
        r2_d = bus_val;
      end
      if (bus.Yin) begin
        y_d = bus_val;
      end
      if (bus.Zin) begin
        z_d     = alu_result;
        carry_d = alu_carry;
        zero_d  = alu_zero;
        dbz_d   = alu_dbz;
      end
      if (conflict_now) begin
        conflict_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r1_q       <= '0;
      r2_q       <= '0;
      y_q        <= '0;
      z_q        <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      dbz_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      y_q        <= y_d;
      z_q        <= z_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      dbz_q      <= dbz_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.Bus         = bus_val;
  assign bus.R1Value     = r1_q;
  assign bus.R2Value     = r2_q;
  assign bus.ZValue      = z_q;
  assign bus.Carry       = carry_q;
  assign bus.ZeroFlag    = zero_q;
  assign bus.DivByZero   = dbz_q;
  assign bus.BusConflict = conflict_q;

endmodule

// File: tb/tb_single_bus_datapath.sv
// Bench for single_bus_datapath: directed strobe sequences, a reference model
// of the datapath checked on every falling edge, and literal expectations
// from the worked examples.
module tb_single_bus_datapath;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         d;
  } alu_t;

  logic Clock;
  logic Reset;
  int   checks;
  int   errors;
  bit   running;

  single_bus_datapath_if #(.WIDTH(W)) bus_if ();

  single_bus_datapath #(.WIDTH(W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_if.slave)
  );

  // Clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model state
  logic [W-1:0] m_r1, m_r2, m_y, m_z;
  logic         m_c, m_zf, m_dz, m_conf;
  logic [W-1:0] e_bus;
  alu_t         e_alu;

  // Bus value: the lone enabled driver, or 0 when idle / none / several
  function automatic logic [W-1:0] ref_bus(input logic idle, input logic o1,
      input logic o2, input logic oz, input logic [W-1:0] v1,
      input logic [W-1:0] v2, input logic [W-1:0] vz);
    int n;
    n = int'(o1) + int'(o2) + int'(oz);
    if (idle || n != 1) return '0;
    if (o1) return v1;
    if (o2) return v2;
    return vz;
  endfunction

  // ALU in plain integer arithmetic
  function automatic alu_t ref_alu(input logic add, input logic sub,
      input logic mul, input logic div, input logic sel_y,
      input logic [W-1:0] y, input logic [W-1:0] b_in);
    alu_t r;
    int   a;
    int   b;
    int   t;
    a = sel_y ? int'(y) : 1;
    b = int'(b_in);
    r = '0;
    if (add) begin
      t = a + b;
      r.res = W'(t);
      r.c = (t > 255);
    end else if (sub) begin
      r.res = W'(a - b);
      r.c = (a < b);
    end else if (mul) begin
      t = a * b;
      r.res = W'(t);
      r.c = (t > 255);
    end else if (div) begin
      if (b == 0) begin
        r.res = 8'hFF;
        r.d = 1'b1;
      end else begin
        r.res = W'(a / b);
      end
    end else begin
      r.res = W'(b);
    end
    r.z = (r.res == 0);
    return r;
  endfunction

  always_comb e_bus = ref_bus(bus_if.End, bus_if.R1out, bus_if.R2out, bus_if.Zout,
                              m_r1, m_r2, m_z);
  always_comb e_alu = ref_alu(bus_if.Add, bus_if.Sub, bus_if.Mul, bus_if.Div,
                              bus_if.SelectY, m_y, e_bus);

  // Model state update
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_r1 <= '0; m_r2 <= '0; m_y <= '0; m_z <= '0;
      m_c <= 1'b0; m_zf <= 1'b0; m_dz <= 1'b0; m_conf <= 1'b0;
    end else if (bus_if.End) begin
      if (bus_if.LoadEn && !bus_if.LoadSel) m_r1 <= bus_if.LoadData;
      if (bus_if.LoadEn &&  bus_if.LoadSel) m_r2 <= bus_if.LoadData;
    end else begin
      if (bus_if.R1in) m_r1 <= e_bus;
      if (bus_if.R2in) m_r2 <= e_bus;
      if (bus_if.Yin)  m_y  <= e_bus;
      if (bus_if.Zin) begin
        m_z <= e_alu.res; m_c <= e_alu.c; m_zf <= e_alu.z; m_dz <= e_alu.d;
      end
      if ((int'(bus_if.R1out) + int'(bus_if.R2out) + int'(bus_if.Zout)) > 1)
        m_conf <= 1'b1;
    end
  end

  // Scoreboard comparison
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge while the bench is running
  always @(negedge Clock) begin
    if (running) begin
      check("bus",      32'(bus_if.Bus),         32'(e_bus));
      check("r1",       32'(bus_if.R1Value),     32'(m_r1));
      check("r2",       32'(bus_if.R2Value),     32'(m_r2));
      check("z",        32'(bus_if.ZValue),      32'(m_z));
      check("carry",    32'(bus_if.Carry),       32'(m_c));
      check("zero",     32'(bus_if.ZeroFlag),    32'(m_zf));
      check("dbz",      32'(bus_if.DivByZero),   32'(m_dz));
      check("conflict", 32'(bus_if.BusConflict), 32'(m_conf));
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_strobes(input logic idle);
    bus_if.R1in = 0; bus_if.R1out = 0; bus_if.R2in = 0; bus_if.R2out = 0;
    bus_if.Add = 0; bus_if.Sub = 0; bus_if.Mul = 0; bus_if.Div = 0;
    bus_if.SelectY = 0; bus_if.Yin = 0; bus_if.Zin = 0; bus_if.Zout = 0;
    bus_if.LoadEn = 0; bus_if.LoadSel = 0; bus_if.LoadData = '0;
    bus_if.End = idle;
  endtask

  task automatic load(input logic sel, input logic [W-1:0] val);
    clear_strobes(1'b1);
    bus_if.LoadEn = 1; bus_if.LoadSel = sel; bus_if.LoadData = val;
    tick();
    clear_strobes(1'b1);
  endtask

  task automatic r1_to_y();
    clear_strobes(1'b0);
    bus_if.R1out = 1; bus_if.Yin = 1;
    tick();
    clear_strobes(1'b1);
  endtask

  // op: 0 add, 1 sub, 2 mul, 3 div; operand A = Y, B = R2 on the bus
  task automatic alu_r2(input int op);
    clear_strobes(1'b0);
    bus_if.R2out = 1; bus_if.SelectY = 1; bus_if.Zin = 1;
    bus_if.Add = (op == 0); bus_if.Sub = (op == 1);
    bus_if.Mul = (op == 2); bus_if.Div = (op == 3);
    tick();
    clear_strobes(1'b1);
  endtask

  task automatic run_op(input logic [W-1:0] yv, input logic [W-1:0] bv, input int op);
    load(1'b0, yv);
    load(1'b1, bv);
    r1_to_y();
    alu_r2(op);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    running = 0;
    clear_strobes(1'b1);
    Reset = 0;
    #1;
    running = 1;
    repeat (2) tick();
    check("reset_bus", 32'(bus_if.Bus), 0);
    check("reset_r1",  32'(bus_if.R1Value), 0);
    check("reset_conf", 32'(bus_if.BusConflict), 0);
    Reset = 1;
    tick();

    // Reset mid-clock with R1 = 0x55
    load(1'b0, 8'h55);
    check("side_load_r1", 32'(bus_if.R1Value), 32'h55);
    #2 Reset = 0;
    #1;
    check("async_reset_r1",  32'(bus_if.R1Value), 0);
    check("async_reset_bus", 32'(bus_if.Bus), 0);
    tick();
    Reset = 1;
    tick();
    check("post_release_r1", 32'(bus_if.R1Value), 0);

    // Side-load then three-step add: 5 + 3
    load(1'b0, 8'd5);
    load(1'b1, 8'd3);
    r1_to_y();
    alu_r2(0);
    clear_strobes(1'b0);
    bus_if.Zout = 1; bus_if.R1in = 1;
    tick();
    clear_strobes(1'b1);
    check("add_r1",    32'(bus_if.R1Value), 8);
    check("add_z",     32'(bus_if.ZValue), 8);
    check("add_carry", 32'(bus_if.Carry), 0);
    check("add_zero",  32'(bus_if.ZeroFlag), 0);

    // Subtract with borrow, then to zero
    run_op(8'd3, 8'd5, 1);
    check("sub_z",     32'(bus_if.ZValue), 32'hFE);
    check("sub_carry", 32'(bus_if.Carry), 1);
    run_op(8'd5, 8'd5, 1);
    check("sub0_z",    32'(bus_if.ZValue), 0);
    check("sub0_zero", 32'(bus_if.ZeroFlag), 1);
    check("sub0_carry", 32'(bus_if.Carry), 0);

    // Multiply overflow and plain
    run_op(8'd20, 8'd13, 2);
    check("mul_z",     32'(bus_if.ZValue), 32'h04);
    check("mul_carry", 32'(bus_if.Carry), 1);
    run_op(8'd3, 8'd4, 2);
    check("mul2_z",     32'(bus_if.ZValue), 12);
    check("mul2_carry", 32'(bus_if.Carry), 0);

    // Divide, divide by zero, then Add clears DivByZero
    run_op(8'd17, 8'd5, 3);
    check("div_z", 32'(bus_if.ZValue), 3);
    load(1'b1, 8'd0);
    alu_r2(3);
    check("div0_z",   32'(bus_if.ZValue), 32'hFF);
    check("div0_dbz", 32'(bus_if.DivByZero), 1);
    alu_r2(0);
    check("add_after_div0_z",   32'(bus_if.ZValue), 17);
    check("add_after_div0_dbz", 32'(bus_if.DivByZero), 0);

    // Same-cycle read/write of R1; LoadEn ignored while running
    load(1'b0, 8'd7);
    load(1'b1, 8'd9);
    clear_strobes(1'b0);
    bus_if.R1out = 1; bus_if.R1in = 1;
    bus_if.LoadEn = 1; bus_if.LoadSel = 1; bus_if.LoadData = 8'hAA;
    tick();
    clear_strobes(1'b1);
    check("self_move_r1",  32'(bus_if.R1Value), 7);
    check("load_ignored_r2", 32'(bus_if.R2Value), 9);

    // Bus conflict: R1out + R2out together
    clear_strobes(1'b0);
    bus_if.R1out = 1; bus_if.R2out = 1; bus_if.R2in = 1;
    #1;
    check("conflict_bus", 32'(bus_if.Bus), 0);
    tick();
    clear_strobes(1'b1);
    check("conflict_set", 32'(bus_if.BusConflict), 1);
    check("conflict_r2_loads_zero", 32'(bus_if.R2Value), 0);

    // Increment through constant operand: 1 + R1
    clear_strobes(1'b0);
    bus_if.R1out = 1; bus_if.Add = 1; bus_if.Zin = 1;
    tick();
    clear_strobes(1'b1);
    check("inc_z", 32'(bus_if.ZValue), 8);
    check("conflict_sticky", 32'(bus_if.BusConflict), 1);

    // Strobes while idle change nothing
    clear_strobes(1'b1);
    bus_if.R1out = 1; bus_if.R2in = 1; bus_if.Zin = 1; bus_if.Yin = 1;
    bus_if.Sub = 1; bus_if.R1in = 1; bus_if.Zout = 1;
    #1;
    check("idle_bus", 32'(bus_if.Bus), 0);
    tick();
    clear_strobes(1'b1);
    check("idle_r1", 32'(bus_if.R1Value), 7);
    check("idle_z",  32'(bus_if.ZValue), 8);

    // Reset mid-sequence with conflicting strobes asserted
    clear_strobes(1'b0);
    bus_if.R1out = 1; bus_if.Zout = 1; bus_if.Zin = 1;
    #2 Reset = 0;
    #1;
    check("midseq_reset_conf", 32'(bus_if.BusConflict), 0);
    check("midseq_reset_z",    32'(bus_if.ZValue), 0);
    clear_strobes(1'b1);
    tick();
    Reset = 1;
    repeat (2) tick();

    running = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
